// File: rtl/vga_obj_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_obj_pkg
// Purpose  : Shared screen geometry, scheduler state codes and the bounds
//            record used by the box-object layer.
// Revision : 1.0 - initial release
// ============================================================================
package vga_obj_pkg;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

  // Stored bound widths: one bit wider than the coordinates so sums never wrap
  localparam int c_bx_w = 11;
  localparam int c_by_w = 10;

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_sample = 2'd1;
  localparam logic [1:0] c_calc   = 2'd2;
  localparam logic [1:0] c_commit = 2'd3;

  typedef struct packed {
    logic [c_bx_w-1:0] left;
    logic [c_bx_w-1:0] right;
    logic [c_by_w-1:0] top;
    logic [c_by_w-1:0] bottom;
  } obj_bounds_t;

endpackage
`default_nettype wire

// File: rtl/vga_obj_bounds.sv
`default_nettype none
// ============================================================================
// Module   : vga_obj_bounds
// Purpose  : Combinational clamped screen bounds for one box object.
// Revision : 1.0 - initial release
// ============================================================================
module vga_obj_bounds
  import vga_obj_pkg::*;
#(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int SIZE_W = 6
) (
  input  logic [X_W-1:0]    i_cx,
  input  logic [Y_W-1:0]    i_cy,
  input  logic [SIZE_W-1:0] i_half,
  input  logic              i_scale,
  output obj_bounds_t       o_bounds
);

  logic [SIZE_W-1:0] w_h;
  logic [X_W:0]      w_cx;
  logic [X_W:0]      w_hx;
  logic [X_W:0]      w_x_lo;
  logic [X_W:0]      w_x_hi;
  logic [Y_W:0]      w_cy;
  logic [Y_W:0]      w_hy;
  logic [Y_W:0]      w_y_lo;
  logic [Y_W:0]      w_y_hi;

  always_comb begin
    w_h    = i_scale ? (i_half >> 1) : i_half;
    w_cx   = {1'b0, i_cx};
    w_hx   = (X_W+1)'(w_h);
    w_cy   = {1'b0, i_cy};
    w_hy   = (Y_W+1)'(w_h);
    // Low edge saturates at zero; high edge saturates at the last visible line
    w_x_lo = (w_cx < w_hx) ? '0 : (w_cx - w_hx);
    w_x_hi = w_cx + w_hx;
    if (w_x_hi > (X_W+1)'(WIDTH - 1)) w_x_hi = (X_W+1)'(WIDTH - 1);
    w_y_lo = (w_cy < w_hy) ? '0 : (w_cy - w_hy);
    w_y_hi = w_cy + w_hy;
    if (w_y_hi > (Y_W+1)'(HEIGHT - 1)) w_y_hi = (Y_W+1)'(HEIGHT - 1);

    o_bounds.left   = c_bx_w'(w_x_lo);
    o_bounds.right  = c_bx_w'(w_x_hi);
    o_bounds.top    = c_by_w'(w_y_lo);
    o_bounds.bottom = c_by_w'(w_y_hi);
  end

endmodule
`default_nettype wire

// File: rtl/vga_object_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_object_scheduler
// Purpose  : Frame-synchronous snapshot / bounds / commit of box objects and
//            registered fixed-priority pixel hit test.
//            Optional: VGA_OBJ_SCALE_EN halves box sizes when game_state==3.
// Revision : 1.0 - initial release
// ============================================================================
module vga_object_scheduler
  import vga_obj_pkg::*;
#(
  parameter  int N_OBJ  = 4,
  parameter  int X_W    = 10,
  parameter  int Y_W    = 9,
  parameter  int SIZE_W = 6,
  localparam int IDX_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                    clk_25mHz,
  input  logic                    reset,
  input  logic                    screenEnd,
  input  logic [31:0]             game_state,
  input  logic [N_OBJ*X_W-1:0]    obj_x,
  input  logic [N_OBJ*Y_W-1:0]    obj_y,
  input  logic [N_OBJ*SIZE_W-1:0] obj_half,
  input  logic [N_OBJ-1:0]        obj_en,
  input  logic [X_W-1:0]          x,
  input  logic [Y_W-1:0]          y,
  input  logic                    active,
  output logic                    hit,
  output logic [IDX_W-1:0]        hit_idx,
  output logic                    busy,
  output logic                    commit,
  output logic                    missed,
  output logic [15:0]             frame_count
);

  logic [1:0]              r_state;
  logic                    r_se_d;
  logic [IDX_W-1:0]        r_idx;
  logic [N_OBJ*X_W-1:0]    r_snap_x;
  logic [N_OBJ*Y_W-1:0]    r_snap_y;
  logic [N_OBJ*SIZE_W-1:0] r_snap_half;
  logic [N_OBJ-1:0]        r_snap_en;
  logic                    r_snap_gs_ok;
  obj_bounds_t             r_shadow [N_OBJ];
  obj_bounds_t             r_live   [N_OBJ];
  logic [N_OBJ-1:0]        r_live_en;
  logic                    r_live_gs_ok;
  logic                    r_missed;
  logic [15:0]             r_frame_count;
  logic                    r_hit;
  logic [IDX_W-1:0]        r_hit_idx;

  logic                    w_rise;
  logic [X_W-1:0]          w_cx;
  logic [Y_W-1:0]          w_cy;
  logic [SIZE_W-1:0]       w_half;
  logic                    w_scale;
  obj_bounds_t             w_bounds;
  logic [N_OBJ-1:0]        w_match;
  logic                    w_any;
  logic [IDX_W-1:0]        w_win;
  logic                    w_hit_next;
  logic                    w_unused_gs;

  assign w_rise      = screenEnd & ~r_se_d;
  assign w_unused_gs = &{1'b0, game_state};

`ifdef VGA_OBJ_SCALE_EN
  logic r_snap_gs3;

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset)                   r_snap_gs3 <= 1'b0;
    else if (r_state == c_sample) r_snap_gs3 <= (game_state == 32'd3);
  end

  assign w_scale = r_snap_gs3;
`else
  assign w_scale = 1'b0;
`endif

  // One bounds unit, time-shared across objects by r_idx
  always_comb begin
    w_cx   = '0;
    w_cy   = '0;
    w_half = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cx   = r_snap_x[i*X_W +: X_W];
        w_cy   = r_snap_y[i*Y_W +: Y_W];
        w_half = r_snap_half[i*SIZE_W +: SIZE_W];
      end
    end
  end

  vga_obj_bounds #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .SIZE_W (SIZE_W)
  ) u_bounds (
    .i_cx     (w_cx),
    .i_cy     (w_cy),
    .i_half   (w_half),
    .i_scale  (w_scale),
    .o_bounds (w_bounds)
  );

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_state       <= c_idle;
      r_se_d        <= 1'b0;
      r_idx         <= '0;
      r_snap_x      <= '0;
      r_snap_y      <= '0;
      r_snap_half   <= '0;
      r_snap_en     <= '0;
      r_snap_gs_ok  <= 1'b0;
      r_live_en     <= '0;
      r_live_gs_ok  <= 1'b0;
      r_missed      <= 1'b0;
      r_frame_count <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      r_se_d <= screenEnd;
      if (w_rise && (r_state != c_idle)) r_missed <= 1'b1;
      case (r_state)
        c_idle: begin
          if (w_rise) r_state <= c_sample;
        end
        c_sample: begin
          r_snap_x     <= obj_x;
          r_snap_y     <= obj_y;
          r_snap_half  <= obj_half;
          r_snap_en    <= obj_en;
          r_snap_gs_ok <= |game_state[1:0];
          r_idx        <= '0;
          r_state      <= c_calc;
        end
        c_calc: begin
          for (int i = 0; i < N_OBJ; i++) begin
            if (r_idx == IDX_W'(i)) r_shadow[i] <= w_bounds;
          end
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(N_OBJ - 1)) r_state <= c_commit;
        end
        c_commit: begin
          // Whole bank swaps in one edge so a frame never mixes old and new
          r_live        <= r_shadow;
          r_live_en     <= r_snap_en;
          r_live_gs_ok  <= r_snap_gs_ok;
          r_frame_count <= r_frame_count + 16'd1;
          r_state       <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < N_OBJ; g++) begin : g_match
      assign w_match[g] = r_live_en[g]
                        && (r_live[g].left < c_bx_w'(x)) && (c_bx_w'(x) < r_live[g].right)
                        && (r_live[g].top  < c_by_w'(y)) && (c_by_w'(y) < r_live[g].bottom);
    end
  endgenerate

  // Ascending scan so the highest matching index wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (w_match[i]) begin
        w_any = 1'b1;
        w_win = IDX_W'(i);
      end
    end
  end

  assign w_hit_next = active & r_live_gs_ok & w_any;

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_hit     <= w_hit_next;
      r_hit_idx <= w_hit_next ? w_win : '0;
    end
  end

  assign hit         = r_hit;
  assign hit_idx     = r_hit_idx;
  assign busy        = (r_state != c_idle);
  assign commit      = (r_state == c_commit);
  assign missed      = r_missed;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_object_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_object_scheduler
// Purpose  : Self-checking bench: directed vector table plus random frames
//            checked against an arithmetic box-coverage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_object_scheduler;

  localparam int N_OBJ  = 4;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int SIZE_W = 6;
  localparam int IDX_W  = 2;

  logic                    clk_25mHz = 1'b0;
  logic                    reset     = 1'b0;
  logic                    screenEnd = 1'b0;
  logic [31:0]             game_state = '0;
  logic [N_OBJ*X_W-1:0]    obj_x = '0;
  logic [N_OBJ*Y_W-1:0]    obj_y = '0;
  logic [N_OBJ*SIZE_W-1:0] obj_half = '0;
  logic [N_OBJ-1:0]        obj_en = '0;
  logic [X_W-1:0]          x = '0;
  logic [Y_W-1:0]          y = '0;
  logic                    active = 1'b0;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    busy;
  logic                    commit;
  logic                    missed;
  logic [15:0]             frame_count;

  vga_object_scheduler #(
    .N_OBJ(N_OBJ), .X_W(X_W), .Y_W(Y_W), .SIZE_W(SIZE_W)
  ) dut (
    .clk_25mHz(clk_25mHz), .reset(reset), .screenEnd(screenEnd),
    .game_state(game_state), .obj_x(obj_x), .obj_y(obj_y),
    .obj_half(obj_half), .obj_en(obj_en), .x(x), .y(y), .active(active),
    .hit(hit), .hit_idx(hit_idx), .busy(busy), .commit(commit),
    .missed(missed), .frame_count(frame_count)
  );

  always #20 clk_25mHz = ~clk_25mHz;

  int checks   = 0;
  int failures = 0;
  int fc_exp   = 0;

  // Values presented on the inputs, and the model of what the live bank holds
  int in_x[N_OBJ], in_y[N_OBJ], in_h[N_OBJ], in_en[N_OBJ], in_gs;
  int m_x[N_OBJ],  m_y[N_OBJ],  m_h[N_OBJ],  m_en[N_OBJ],  m_gs;

  typedef struct {
    int fr;
    int px;
    int py;
    bit act;
    bit eh;
    int ei;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N_OBJ; i++) begin
      obj_x[i*X_W +: X_W]          = X_W'(in_x[i]);
      obj_y[i*Y_W +: Y_W]          = Y_W'(in_y[i]);
      obj_half[i*SIZE_W +: SIZE_W] = SIZE_W'(in_h[i]);
      obj_en[i]                    = in_en[i][0];
    end
    game_state = in_gs;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N_OBJ; i++) begin
      in_x[i]  = $urandom_range(0, 700);
      in_y[i]  = $urandom_range(0, 511);
      in_h[i]  = $urandom_range(0, 63);
      in_en[i] = $urandom_range(0, 1);
    end
    in_gs = $urandom_range(0, 7);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_OBJ; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_h[i] = 0; m_en[i] = 0;
    end
    m_gs = 0;
  endtask

  // A pixel is covered by a box when it lies strictly inside the clamped extent
  function automatic void model_pix(input int px, input int py, input bit act,
                                    output bit eh, output int ei);
    int h, l, r, t, b;
    eh = 1'b0;
    ei = 0;
    if (!act || (m_gs & 3) == 0) return;
    for (int i = 0; i < N_OBJ; i++) begin
      h = m_h[i];
`ifdef VGA_OBJ_SCALE_EN
      if (m_gs == 3) h = h / 2;
`endif
      l = (m_x[i] - h < 0)   ? 0   : m_x[i] - h;
      r = (m_x[i] + h > 639) ? 639 : m_x[i] + h;
      t = (m_y[i] - h < 0)   ? 0   : m_y[i] - h;
      b = (m_y[i] + h > 479) ? 479 : m_y[i] + h;
      if (m_en[i] != 0 && l < px && px < r && t < py && py < b) begin
        eh = 1'b1;
        ei = i;
      end
    end
  endfunction

  task automatic pix(input int px, input int py, input bit act,
                     output bit h, output int idx);
    x      = X_W'(px);
    y      = Y_W'(py);
    active = act;
    @(posedge clk_25mHz); #1;
    h   = hit;
    idx = int'(hit_idx);
  endtask

  task automatic pix_model(input int px, input int py, input bit act, input string tag);
    bit h, eh;
    int idx, ei;
    pix(px, py, act, h, idx);
    model_pix(px, py, act, eh, ei);
    check({tag, "_hit"}, h, eh);
    check({tag, "_idx"}, idx, ei);
  endtask

  // Strobe screenEnd, scramble inputs after the sample cycle, count commits
  task automatic run_frame(input bit second_edge, output int lat, output int ncommit);
    int p_x[N_OBJ], p_y[N_OBJ], p_h[N_OBJ], p_en[N_OBJ], p_gs;
    apply_inputs();
    p_x = in_x; p_y = in_y; p_h = in_h; p_en = in_en; p_gs = in_gs;
    @(posedge clk_25mHz); #1;
    screenEnd = 1'b1;
    lat     = -1;
    ncommit = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_25mHz); #1;
      if (c == 1) begin
        check("busy_in_sample", busy, 1);
        screenEnd = 1'b0;
      end
      if (c == 2) begin
        randomize_inputs();
        apply_inputs();
      end
      if (second_edge && c == 3) screenEnd = 1'b1;
      if (second_edge && c == 4) screenEnd = 1'b0;
      if (commit) begin
        ncommit++;
        if (lat < 0) lat = c;
      end
    end
    if (ncommit > 0) begin
      m_x = p_x; m_y = p_y; m_h = p_h; m_en = p_en; m_gs = p_gs;
    end
    check("busy_after_frame", busy, 0);
  endtask

  task automatic setup_frame(input int id);
    for (int i = 0; i < N_OBJ; i++) begin
      in_x[i] = 0; in_y[i] = 0; in_h[i] = 0; in_en[i] = 0;
    end
    case (id)
      0: begin
        in_gs = 1;
        in_x[0] = 100; in_y[0] = 100; in_h[0] = 20; in_en[0] = 1;
        in_x[1] = 5;   in_y[1] = 470; in_h[1] = 20; in_en[1] = 1;
      end
      1: begin
        in_gs = 2;
        in_x[0] = 320; in_y[0] = 240; in_h[0] = 10; in_en[0] = 1;
        in_x[2] = 320; in_y[2] = 240; in_h[2] = 5;  in_en[2] = 1;
        in_x[3] = 320; in_y[3] = 240; in_h[3] = 10; in_en[3] = 1;
      end
      2: begin
        in_gs = 3;
        in_x[0] = 200; in_y[0] = 200; in_h[0] = 20; in_en[0] = 1;
      end
      default: begin
        in_gs = 4;
        in_x[0] = 200; in_y[0] = 200; in_h[0] = 20; in_en[0] = 1;
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, nc, cur_fr;
    bit  h;
    int  idx;

    model_clear();
    for (int i = 0; i < N_OBJ; i++) begin
      in_x[i] = 0; in_y[i] = 0; in_h[i] = 0; in_en[i] = 0;
    end
    in_gs = 0;

    // Directed vectors: frame id, pixel, active, expected hit and index
    vecs.push_back('{0, 110,  90, 1'b1, 1'b1, 0});
    vecs.push_back('{0,  80, 100, 1'b1, 1'b0, 0});
    vecs.push_back('{0,  81, 100, 1'b1, 1'b1, 0});
    vecs.push_back('{0, 120, 100, 1'b1, 1'b0, 0});
    vecs.push_back('{0, 100,  80, 1'b1, 1'b0, 0});
    vecs.push_back('{0, 100, 119, 1'b1, 1'b1, 0});
    vecs.push_back('{0, 110,  90, 1'b0, 1'b0, 0});
    vecs.push_back('{0,   1, 471, 1'b1, 1'b1, 1});
    vecs.push_back('{0,   0, 471, 1'b1, 1'b0, 0});
    vecs.push_back('{0,  24, 471, 1'b1, 1'b1, 1});
    vecs.push_back('{0,  25, 471, 1'b1, 1'b0, 0});
    vecs.push_back('{0,   3, 451, 1'b1, 1'b1, 1});
    vecs.push_back('{0,   3, 450, 1'b1, 1'b0, 0});
    vecs.push_back('{0,   3, 478, 1'b1, 1'b1, 1});
    vecs.push_back('{0, 600, 300, 1'b1, 1'b0, 0});
    vecs.push_back('{1, 320, 240, 1'b1, 1'b1, 3});
    vecs.push_back('{1, 311, 240, 1'b1, 1'b1, 3});
    vecs.push_back('{1, 310, 240, 1'b1, 1'b0, 0});
    vecs.push_back('{1, 329, 249, 1'b1, 1'b1, 3});
    vecs.push_back('{1, 330, 240, 1'b1, 1'b0, 0});
`ifdef VGA_OBJ_SCALE_EN
    vecs.push_back('{2, 212, 200, 1'b1, 1'b0, 0});
`else
    vecs.push_back('{2, 212, 200, 1'b1, 1'b1, 0});
`endif
    vecs.push_back('{2, 209, 200, 1'b1, 1'b1, 0});
    vecs.push_back('{2, 200, 200, 1'b1, 1'b1, 0});
    vecs.push_back('{3, 200, 200, 1'b1, 1'b0, 0});

    // Reset values, checked while reset is held and just after release
    repeat (3) @(posedge clk_25mHz);
    #1;
    check("rst_hit", hit, 0);
    check("rst_idx", hit_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_commit", commit, 0);
    check("rst_missed", missed, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b1;
    @(posedge clk_25mHz); #1;
    check("post_rst_busy", busy, 0);

    // Coarse scan of the visible frame: no object can hit yet
    for (int yy = 0; yy < 480; yy += 16)
      for (int xx = 0; xx < 640; xx += 16)
        pix_model(xx, yy, 1'b1, "scan_reset");
    check("scan_frame_count", frame_count, 0);

    cur_fr = -1;
    foreach (vecs[k]) begin
      if (vecs[k].fr != cur_fr) begin
        cur_fr = vecs[k].fr;
        setup_frame(cur_fr);
        run_frame(1'b0, lat, nc);
        fc_exp++;
        check("commit_latency", lat, 6);
        check("commit_count", nc, 1);
        check("frame_count", frame_count, fc_exp);
      end
      pix(vecs[k].px, vecs[k].py, vecs[k].act, h, idx);
      check($sformatf("vec%0d_hit", k), h, vecs[k].eh);
      check($sformatf("vec%0d_idx", k), idx, vecs[k].ei);
    end
    check("missed_clear", missed, 0);

    // Second edge while busy: ignored, flagged, and missed stays set afterwards
    setup_frame(0);
    run_frame(1'b1, lat, nc);
    fc_exp++;
    check("missed_latency", lat, 6);
    check("missed_commit_count", nc, 1);
    check("missed_set", missed, 1);
    check("missed_frame_count", frame_count, fc_exp);
    pix_model(110, 90, 1'b1, "missed_pix");
    setup_frame(1);
    run_frame(1'b0, lat, nc);
    fc_exp++;
    check("missed_sticky", missed, 1);

    // Reset in the middle of CALC wipes the live bank
    setup_frame(0);
    run_frame(1'b0, lat, nc);
    fc_exp++;
    pix_model(110, 90, 1'b1, "pre_midrst");
    setup_frame(1);
    apply_inputs();
    @(posedge clk_25mHz); #1;
    screenEnd = 1'b1;
    repeat (3) @(posedge clk_25mHz);
    #1;
    screenEnd = 1'b0;
    reset     = 1'b0;
    @(posedge clk_25mHz); #1;
    check("midrst_busy", busy, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_missed", missed, 0);
    reset  = 1'b1;
    fc_exp = 0;
    model_clear();
    pix_model(110, 90, 1'b1, "midrst_pix");
    pix_model(320, 240, 1'b1, "midrst_pix2");
    setup_frame(0);
    run_frame(1'b0, lat, nc);
    fc_exp++;
    check("midrst_relatency", lat, 6);
    check("midrst_frame_count2", frame_count, fc_exp);
    pix_model(110, 90, 1'b1, "midrst_pix3");

    // Random frames checked against the coverage model
    for (int f = 0; f < 25; f++) begin
      randomize_inputs();
      run_frame(1'b0, lat, nc);
      fc_exp++;
      check("rand_latency", lat, 6);
      check("rand_frame_count", frame_count, fc_exp);
      for (int p = 0; p < 60; p++) begin
        int o, px, py;
        bit act;
        o   = $urandom_range(0, N_OBJ - 1);
        act = ($urandom_range(0, 4) != 0);
        if (p % 4 == 0) begin
          px = $urandom_range(0, 639);
          py = $urandom_range(0, 479);
        end else begin
          px = m_x[o] + $urandom_range(0, 2 * m_h[o] + 4) - m_h[o] - 2;
          py = m_y[o] + $urandom_range(0, 2 * m_h[o] + 4) - m_h[o] - 2;
          if (px < 0) px = 0;
          if (px > 1023) px = 1023;
          if (py < 0) py = 0;
          if (py > 511) py = 511;
        end
        pix_model(px, py, act, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
